stream_cmd_driver: RTL
======================

# stream_cmd_driver

Synthesizable, parametrised command-stream driver that replaces the byte-command loop of the simulation harness with hardware. It accepts a byte stream of single-byte commands plus operand bytes, drives a generated module's packed input vector, reset and clock-enable, and returns snapshots of its packed output vector as a byte stream. It sits between a host byte transport (UART/FIFO bridge) and the device under test, so the same host-side test scripts run against simulation or an FPGA.

## Interface
- INPUT_WIDTH, 8: bits of packed DUT input vector; IN_BYTES = ceil(INPUT_WIDTH/8).
- OUTPUT_WIDTH, 32: bits of packed DUT output vector; OUT_BYTES = 4*ceil(OUTPUT_WIDTH/32).
- COUNT_WIDTH, 16: width of the multi-step counter; range 8..32.
- clk  in  1  single clock for the block and the DUT.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  8  command/operand byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- out_data  out  8  response byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  response byte consumed when out_valid & out_ready.
- dut_in  out  INPUT_WIDTH  packed DUT inputs.
- dut_out  in  OUTPUT_WIDTH  packed DUT outputs.
- dut_rst  out  1  active-high DUT reset.
- dut_ce  out  1  DUT clock enable; one high cycle = one DUT step.
- done  out  1  finish command received.
- error  out  1  unknown command received.

## Operation
- Command codes: 104 'h' sample; 105 'i' finish; 106 'j' assert dut_rst; 107 'k' deassert dut_rst; 108 'l' step one; 109 'm' load inputs (IN_BYTES operands follow); 110 'n' step N (COUNT_WIDTH/8 operand bytes, rounded up, little-endian).
- States: IDLE, LOAD, COUNT, STEP, SEND, DONE, ERROR.
- IDLE: in_ready=1; decodes each accepted byte.
- 'm' -> LOAD: bytes shift into shadow register little-endian (first byte = bits 7:0); dut_in updated atomically on the edge accepting the last byte; padding bits above INPUT_WIDTH discarded; then IDLE.
- 'l' -> STEP with remaining=1. 'n' -> COUNT, collect operand, then STEP with remaining=N; N=0 returns to IDLE with no dut_ce pulse.
- STEP: dut_ce=1 every cycle, remaining decrements, in_ready=0; exits to IDLE after the cycle where remaining reaches 0.
- 'h' -> SEND: dut_out snapshotted, zero-extended to OUT_BYTES*8 on the accepting edge; bytes emitted LSB first, each held until out_ready; IDLE after last handshake. in_ready=0 throughout.
- 'j'/'k': dut_rst set/cleared on the accepting edge; stay IDLE.
- 'i' -> DONE: done=1, in_ready=0, terminal until rst.
- Any other code -> ERROR: error=1, in_ready=0, terminal until rst.
- Reset values: in_ready=0 in the reset cycle then 1; out_valid=0; out_data=0; dut_in=0; dut_rst=1; dut_ce=0; done=0; error=0; state IDLE.
- Reset mid-operation: all counters, shadow and snapshot cleared; partial loads and sends abandoned; no byte emitted.

## Timing
- Command accepted at edge T: dut_rst change visible T+1; 'l' gives dut_ce=1 in cycle T+1 only, in_ready=1 again at T+2.
- 'n' with N: dut_ce high for exactly N consecutive cycles starting the cycle after the final operand byte.
- 'h' at T: out_valid=1 from T+1; with out_ready tied high, OUT_BYTES bytes in consecutive cycles, in_ready=1 the cycle after the last.
- Snapshot reflects dut_out sampled at T, unaffected by later dut_out changes.
- Throughput: one input byte per cycle in IDLE/LOAD/COUNT.

## Configuration
- STREAM_CMD_DRIVER_ERRREPORT_EN defined: on unknown code, enter SEND-like path emitting 0xEE then the offending byte (subject to out_ready), then ERROR.
- Undefined: unknown code goes straight to ERROR; no bytes emitted.

## Structure
- Package stream_cmd_driver_pkg: command code localparams, state enum, error marker 0xEE.
- Sub-module stream_cmd_driver_tx: loadable snapshot shift register plus byte counter with valid/ready output; parametrised by byte count.

## Test plan
- Reset then 'h' with dut_out=40'h12_3456_789A, INPUT_WIDTH=12, OUTPUT_WIDTH=40 -> bytes 9A 78 56 34 12 00 00 00; dut_rst=1, dut_in=0 throughout.
- 'm' 0xCD 0xFB -> dut_in=12'hBCD, changes only on edge of second operand, never partial.
- 'k', 'n' 0x05 0x00 -> dut_rst low, then exactly 5 dut_ce cycles; 'n' 0x00 0x00 -> zero pulses.
- 'h' with out_ready toggling 1/0 and dut_out changed mid-send -> bytes of original snapshot, none dropped or duplicated.
- Byte 0x41 -> error=1, in_ready=0; with macro, bytes EE 41 emitted first; 'i' after rst -> done=1.
- rst asserted during STEP of N=100 and mid-SEND -> outputs at reset values next cycle, out_valid=0, no further dut_ce.

Source files
------------

// File: rtl/stream_cmd_driver_pkg.sv
// Shared command codes, FSM state encodings and helpers for the stream command driver.
package stream_cmd_driver_pkg;

  localparam logic [7:0] CMD_SAMPLE  = 8'h68;
  localparam logic [7:0] CMD_FINISH  = 8'h69;
  localparam logic [7:0] CMD_RST_ON  = 8'h6A;
  localparam logic [7:0] CMD_RST_OFF = 8'h6B;
  localparam logic [7:0] CMD_STEP    = 8'h6C;
  localparam logic [7:0] CMD_LOAD    = 8'h6D;
  localparam logic [7:0] CMD_STEPN   = 8'h6E;

  localparam logic [7:0] ERR_MARK = 8'hEE;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_COUNT = 3'd2;
  localparam state_t ST_STEP  = 3'd3;
  localparam state_t ST_SEND  = 3'd4;
  localparam state_t ST_DONE  = 3'd5;
  localparam state_t ST_ERROR = 3'd6;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic logic known_cmd(input logic [7:0] b);
    return (b >= CMD_SAMPLE) && (b <= CMD_STEPN);
  endfunction

endpackage

// File: rtl/stream_cmd_driver_tx.sv
// Response serializer: loadable snapshot shift register emitting bytes LSB first
// over a valid/ready handshake, with a count of bytes still to send.
module stream_cmd_driver_tx #(
  parameter int NBYTES = 4,
  localparam int CNT_W = $clog2(NBYTES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [NBYTES*8-1:0] load_data,
  input  logic [CNT_W-1:0]    load_cnt,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                last
);

  logic [NBYTES*8-1:0] sreg;
  logic [CNT_W-1:0]    remain;
  logic                take;

  assign take      = out_valid & out_ready;
  assign out_valid = (remain != '0);
  assign out_data  = out_valid ? sreg[7:0] : 8'h00;
  assign last      = take && (remain == CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg   <= '0;
      remain <= '0;
    end else if (load) begin
      sreg   <= load_data;
      remain <= load_cnt;
    end else if (take) begin
      sreg   <= sreg >> 8;
      remain <= remain - CNT_W'(1);
    end
  end

endmodule

// File: rtl/stream_cmd_driver.sv
// Byte-command driver for a generated DUT: loads inputs, steps the clock enable, samples outputs.
// Optional STREAM_CMD_DRIVER_ERRREPORT_EN: unknown codes emit 0xEE and the offending byte before halting.
module stream_cmd_driver
  import stream_cmd_driver_pkg::*;
#(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 32,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INPUT_WIDTH-1:0]  dut_in,
  input  logic [OUTPUT_WIDTH-1:0] dut_out,
  output logic                    dut_rst,
  output logic                    dut_ce,
  output logic                    done,
  output logic                    error
);

  localparam int IN_BYTES  = ceil_div(INPUT_WIDTH, 8);
  localparam int OUT_BYTES = 4 * ceil_div(OUTPUT_WIDTH, 32);
  localparam int CNT_BYTES = ceil_div(COUNT_WIDTH, 8);
  localparam int MAX_BYTES = (IN_BYTES > CNT_BYTES) ? IN_BYTES : CNT_BYTES;
  localparam int IDX_W     = $clog2(MAX_BYTES + 1);
  localparam int TX_W      = OUT_BYTES * 8;
  localparam int TXC_W     = $clog2(OUT_BYTES + 1);

  state_t                 state;
  logic                   ready_en;
  logic [IDX_W-1:0]       idx;
  logic [IN_BYTES*8-1:0]  shadow, shadow_nxt;
  logic [CNT_BYTES*8-1:0] cnt_op, cnt_op_nxt;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   accept, op_last;
  logic                   tx_load, tx_last;
  logic [TX_W-1:0]        tx_data;
  logic [TXC_W-1:0]       tx_cnt;
`ifdef STREAM_CMD_DRIVER_ERRREPORT_EN
  logic                   err_pend;
`endif

  // ready_en holds in_ready low for the reset cycle itself
  assign in_ready = ready_en && ((state == ST_IDLE) || (state == ST_LOAD) || (state == ST_COUNT));
  assign accept   = in_valid && in_ready;
  assign dut_ce   = (state == ST_STEP);
  assign done     = (state == ST_DONE);
  assign error    = (state == ST_ERROR);
  assign op_last  = (state == ST_LOAD) ? (idx == IDX_W'(IN_BYTES - 1))
                                       : (idx == IDX_W'(CNT_BYTES - 1));

  always_comb begin
    shadow_nxt             = shadow;
    shadow_nxt[idx*8 +: 8] = in_data;
    cnt_op_nxt             = cnt_op;
    cnt_op_nxt[idx*8 +: 8] = in_data;
  end

  always_comb begin
    tx_load = 1'b0;
    tx_data = TX_W'(dut_out);
    tx_cnt  = TXC_W'(OUT_BYTES);
    if (accept && (state == ST_IDLE)) begin
      if (in_data == CMD_SAMPLE) begin
        tx_load = 1'b1;
      end
`ifdef STREAM_CMD_DRIVER_ERRREPORT_EN
      else if (!known_cmd(in_data)) begin
        tx_load = 1'b1;
        tx_data = TX_W'({in_data, ERR_MARK});
        tx_cnt  = TXC_W'(2);
      end
`endif
    end
  end

  stream_cmd_driver_tx #(.NBYTES(OUT_BYTES)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (tx_load),
    .load_data (tx_data),
    .load_cnt  (tx_cnt),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .last      (tx_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      ready_en  <= 1'b0;
      idx       <= '0;
      shadow    <= '0;
      cnt_op    <= '0;
      remaining <= '0;
      dut_in    <= '0;
      dut_rst   <= 1'b1;
`ifdef STREAM_CMD_DRIVER_ERRREPORT_EN
      err_pend  <= 1'b0;
`endif
    end else begin
      ready_en <= 1'b1;
      case (state)
        ST_IDLE: if (accept) begin
          idx <= '0;
          case (in_data)
            CMD_SAMPLE:  state <= ST_SEND;
            CMD_FINISH:  state <= ST_DONE;
            CMD_RST_ON:  dut_rst <= 1'b1;
            CMD_RST_OFF: dut_rst <= 1'b0;
            CMD_STEP: begin
              remaining <= COUNT_WIDTH'(1);
              state     <= ST_STEP;
            end
            CMD_LOAD:    state <= ST_LOAD;
            CMD_STEPN:   state <= ST_COUNT;
            default: begin
`ifdef STREAM_CMD_DRIVER_ERRREPORT_EN
              err_pend <= 1'b1;
              state    <= ST_SEND;
`else
              state    <= ST_ERROR;
`endif
            end
          endcase
        end
        ST_LOAD: if (accept) begin
          shadow <= shadow_nxt;
          idx    <= idx + IDX_W'(1);
          if (op_last) begin
            dut_in <= shadow_nxt[INPUT_WIDTH-1:0];
            state  <= ST_IDLE;
          end
        end
        ST_COUNT: if (accept) begin
          cnt_op <= cnt_op_nxt;
          idx    <= idx + IDX_W'(1);
          if (op_last) begin
            remaining <= cnt_op_nxt[COUNT_WIDTH-1:0];
            state     <= (cnt_op_nxt[COUNT_WIDTH-1:0] == '0) ? ST_IDLE : ST_STEP;
          end
        end
        ST_STEP: begin
          remaining <= remaining - COUNT_WIDTH'(1);
          if (remaining == COUNT_WIDTH'(1)) state <= ST_IDLE;
        end
        ST_SEND: if (tx_last) begin
`ifdef STREAM_CMD_DRIVER_ERRREPORT_EN
          state    <= err_pend ? ST_ERROR : ST_IDLE;
          err_pend <= 1'b0;
`else
          state    <= ST_IDLE;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
